// File: rtl/npu_pkg.sv
// Shared definitions for the host-side NPU stream controller.
package npu_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned CNT_W_DEF  = 8;

  // Job phase: config words first, then input pushes and output reads in parallel
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CFG  = 2'd1,
    ST_XFER = 2'd2
  } state_t;

endpackage

// File: rtl/npu_host_stream_ctrl_if.sv
// Host word streams and NPU FIFO signals seen by the host stream controller.
// master = controller side, slave = host adapter / FIFO side.
interface npu_host_stream_ctrl_if #(
  parameter int unsigned DATA_W = npu_pkg::DATA_W_DEF
);

  logic [DATA_W-1:0] host_data_in;
  logic              host_data_valid;
  logic              host_data_ready;
  logic [DATA_W-1:0] host_out_data;
  logic              host_out_valid;
  logic              host_out_ready;
  logic              cfg_fifo_wr_en;
  logic [DATA_W-1:0] cfg_fifo_data;
  logic              cfg_fifo_full;
  logic              in_fifo_wr_en;
  logic [DATA_W-1:0] in_fifo_data;
  logic              in_fifo_full;
  logic              out_fifo_rd_en;
  logic [DATA_W-1:0] out_fifo_data;
  logic              out_fifo_empty;

  modport master (
    input  host_data_in, host_data_valid, host_out_ready,
    input  cfg_fifo_full, in_fifo_full, out_fifo_data, out_fifo_empty,
    output host_data_ready, host_out_data, host_out_valid,
    output cfg_fifo_wr_en, cfg_fifo_data, in_fifo_wr_en, in_fifo_data, out_fifo_rd_en
  );

  modport slave (
    output host_data_in, host_data_valid, host_out_ready,
    output cfg_fifo_full, in_fifo_full, out_fifo_data, out_fifo_empty,
    input  host_data_ready, host_out_data, host_out_valid,
    input  cfg_fifo_wr_en, cfg_fifo_data, in_fifo_wr_en, in_fifo_data, out_fifo_rd_en
  );

endinterface

// File: rtl/npu_out_skid.sv
// One-entry result register between the NPU output FIFO and the host.
// A read issued in one cycle returns data the next; that data is captured and
// held with valid until the host takes it.
module npu_out_skid #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              i_rd_issue,
  input  logic [DATA_W-1:0] i_rd_data,
  input  logic              i_out_ready,
  output logic              o_inflight,
  output logic              o_out_valid,
  output logic [DATA_W-1:0] o_out_data
);

  logic              r_inflight;
  logic              r_valid;
  logic [DATA_W-1:0] r_data;

  // Track the outstanding read, capture its data, release on host handshake
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_inflight <= 1'b0;
      r_valid    <= 1'b0;
      r_data     <= '0;
    end else begin
      r_inflight <= i_rd_issue;
      if (r_inflight) begin
        r_data  <= i_rd_data;
        r_valid <= 1'b1;
      end else if (r_valid && i_out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_inflight  = r_inflight;
  assign o_out_valid = r_valid;
  assign o_out_data  = r_data;

endmodule

// File: rtl/npu_host_stream_ctrl.sv
// Host-side producer/consumer for the NPU FIFOs: per job pushes N config words,
// then M input words while concurrently draining K result words to the host.
module npu_host_stream_ctrl
  import npu_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             host_start,
  input  logic [CNT_W-1:0] host_num_cfg,
  input  logic [CNT_W-1:0] host_num_in,
  input  logic [CNT_W-1:0] host_num_out,
  output logic             busy,
  output logic             done,
  npu_host_stream_ctrl_if.master bus
);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cfg_rem;
  logic [CNT_W-1:0]  r_in_rem;
  logic [CNT_W-1:0]  r_out_rem;
  logic              r_done_zero;

  logic              w_ready;
  logic              w_push;
  logic              w_cfg_push;
  logic              w_in_push;
  logic              w_rd_issue;
  logic              w_inflight;
  logic              w_out_valid;
  logic [DATA_W-1:0] w_out_data;
  logic              w_xfer_done;

  // Host-side ready depends on phase and on the target FIFO having room
  always_comb begin
    w_ready = 1'b0;
    case (r_state)
      ST_CFG:  w_ready = !bus.cfg_fifo_full;
      ST_XFER: w_ready = (r_in_rem != '0) && !bus.in_fifo_full;
      default: w_ready = 1'b0;
    endcase
  end

  assign w_push      = bus.host_data_valid && w_ready;
  assign w_cfg_push  = (r_state == ST_CFG)  && w_push;
  assign w_in_push   = (r_state == ST_XFER) && w_push;
  assign w_rd_issue  = (r_state == ST_XFER) && (r_out_rem != '0) && !bus.out_fifo_empty &&
                       !w_inflight && !w_out_valid;
  assign w_xfer_done = (r_state == ST_XFER) && (r_in_rem == '0) && (r_out_rem == '0) &&
                       !w_inflight && !w_out_valid;

  assign bus.host_data_ready = w_ready;
  assign bus.cfg_fifo_wr_en  = w_cfg_push;
  assign bus.cfg_fifo_data   = bus.host_data_in;
  assign bus.in_fifo_wr_en   = w_in_push;
  assign bus.in_fifo_data    = bus.host_data_in;
  assign bus.out_fifo_rd_en  = w_rd_issue;
  assign bus.host_out_valid  = w_out_valid;
  assign bus.host_out_data   = w_out_data;

  assign busy = (r_state != ST_IDLE);
  // An empty job reports done from IDLE via a registered flag; a real job
  // reports it in its final XFER cycle.
  assign done = r_done_zero || w_xfer_done;

  npu_out_skid #(.DATA_W(DATA_W)) u_out_skid (
    .CLK         (CLK),
    .RST         (RST),
    .i_rd_issue  (w_rd_issue),
    .i_rd_data   (bus.out_fifo_data),
    .i_out_ready (bus.host_out_ready),
    .o_inflight  (w_inflight),
    .o_out_valid (w_out_valid),
    .o_out_data  (w_out_data)
  );

  // Job FSM and per-phase remaining-word counters
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state     <= ST_IDLE;
      r_cfg_rem   <= '0;
      r_in_rem    <= '0;
      r_out_rem   <= '0;
      r_done_zero <= 1'b0;
    end else begin
      r_done_zero <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (host_start) begin
            r_cfg_rem <= host_num_cfg;
            r_in_rem  <= host_num_in;
            r_out_rem <= host_num_out;
            if (host_num_cfg != '0)
              r_state <= ST_CFG;
            else if ((host_num_in | host_num_out) != '0)
              r_state <= ST_XFER;
            else
              r_done_zero <= 1'b1;
          end
        end
        ST_CFG: begin
          if (w_cfg_push && (r_cfg_rem != '0)) begin
            r_cfg_rem <= r_cfg_rem - CNT_W'(1);
            if (r_cfg_rem == CNT_W'(1))
              r_state <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (w_in_push && (r_in_rem != '0))
            r_in_rem <= r_in_rem - CNT_W'(1);
          if (w_inflight && (r_out_rem != '0))
            r_out_rem <= r_out_rem - CNT_W'(1);
          if (w_xfer_done)
            r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
